// File: rtl/async_sram_model.sv
// Clocked behavioural model of an asynchronous SRAM with byte lanes, emulated
// read access/hold latency, saturating activity counters and sticky misuse flags.
module async_sram_model #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 19,
  parameter int DEPTH      = 524288,
  parameter int ACCESS_CYC = 4,
  parameter int HOLD_CYC   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inout  wire  [DATA_W-1:0]     data,
  input  logic                  ce_b,
  input  logic                  we_b,
  input  logic                  oe_b,
  input  logic [DATA_W/8-1:0]   be_b,
  input  logic [ADDR_W-1:0]     addr,
  output logic                  rd_valid,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count,
  output logic                  err_range,
  output logic                  err_contention
);
  localparam int NB      = DATA_W / 8;
  localparam int CNT_MAX = (ACCESS_CYC > HOLD_CYC) ? ACCESS_CYC : HOLD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

  localparam logic [CNT_W-1:0]  ACC_L   = CNT_W'(ACCESS_CYC);
  localparam logic [CNT_W-1:0]  HOLD_L  = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_VALID  = 2'd3;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dq;

  logic              wen;
  logic              ren;
  logic              wr_ok;
  logic              q_ok;
  logic              addr_chg;
  logic [NB-1:0]     lane_en;
  logic [DATA_W-1:0] drive;

  assign wen      = !ce_b && !we_b;
  assign ren      = !ce_b && !oe_b && we_b;
  assign wr_ok    = {1'b0, addr} < DEPTH_L;
  assign q_ok     = {1'b0, addr_q} < DEPTH_L;
  assign addr_chg = addr != addr_q;

  // Memory contents are deliberately never reset; unwritten words stay undefined.
  always_ff @(posedge clk) begin
    if (wen && wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (!be_b[i]) mem[addr][8*i +: 8] <= data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      addr_q         <= '0;
      cnt            <= '0;
      dq             <= '0;
      rd_count       <= '0;
      wr_count       <= '0;
      err_range      <= 1'b0;
      err_contention <= 1'b0;
    end else begin
      if (wen) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        if (!wr_ok) err_range <= 1'b1;
        if (!oe_b) err_contention <= 1'b1;
      end
      if (!ren) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            state  <= S_ACCESS;
            addr_q <= addr;
            cnt    <= CNT_ONE;
          end
          S_ACCESS: begin
            if (addr_chg) begin
              addr_q <= addr;
              cnt    <= CNT_ONE;
            end else if (cnt == ACC_L) begin
              dq    <= q_ok ? mem[addr_q] : {DATA_W{1'bx}};
              state <= S_VALID;
              if (!q_ok) err_range <= 1'b1;
              if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_VALID: begin
            if (addr_chg) begin
              addr_q <= addr;
              cnt    <= CNT_ONE;
              state  <= (HOLD_CYC > 0) ? S_HOLD : S_ACCESS;
            end
          end
          S_HOLD: begin
            // Address may keep moving during hold; the hold window is not restarted.
            addr_q <= addr;
            if (cnt == HOLD_L) begin
              state <= S_ACCESS;
              cnt   <= CNT_ONE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign rd_valid = (state == S_VALID) && ren;
  assign lane_en  = (ren && state != S_IDLE) ? ~be_b : '0;
  assign drive    = (state == S_VALID || state == S_HOLD) ? dq : {DATA_W{1'bx}};

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign data[8*i +: 8] = lane_en[i] ? drive[8*i +: 8] : 8'bz;
  end
endmodule

// File: tb/tb_async_sram_model.sv
// Bench for async_sram_model: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a timeline-based reference.
module tb_async_sram_model;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 200;
  localparam int ACC    = 4;
  localparam int HOLD   = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce_b  = 1'b1;
  logic        we_b  = 1'b1;
  logic        oe_b  = 1'b1;
  logic [1:0]  be_b  = 2'b11;
  logic [7:0]  addr  = 8'd0;
  logic [15:0] drv   = 16'd0;
  wire  [15:0] data;
  logic        rd_valid;
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  logic        err_range;
  logic        err_contention;

  int n_cmp  = 0;
  int n_fail = 0;

  assign data = we_b ? 16'bz : drv;
  always #5 clk = ~clk;

  async_sram_model #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .ACCESS_CYC(ACC), .HOLD_CYC(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .ce_b(ce_b), .we_b(we_b),
    .oe_b(oe_b), .be_b(be_b), .addr(addr), .rd_valid(rd_valid),
    .rd_count(rd_count), .wr_count(wr_count), .err_range(err_range),
    .err_contention(err_contention)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // An undriven lane reads z on a 4-state simulator and 0 on a 2-state one.
  task automatic chk_z(input string name, input logic [7:0] act);
    n_cmp++;
    if (!(act === 8'hzz || act === 8'h00)) begin
      n_fail++;
      $display("FAIL %s: got %h expected undriven (z) at %0t", name, act, $time);
    end
  endtask

  // Reference: memory with per-lane known mask, and a read timeline expressed
  // as the edge numbers at which the hold window ends and data gets captured.
  logic [15:0] m_mem   [256];
  bit   [1:0]  m_known [256];
  int          e;
  bit          m_active, m_valid, m_hold;
  int          cap_e, hold_e;
  logic [7:0]  m_tgt;
  logic [15:0] m_dq;
  bit   [1:0]  m_dqk;
  int          m_rdc, m_wrc;
  bit          m_er, m_ec;

  always @(posedge clk or negedge rst_n) begin
    bit wen_m, ren_m;
    if (!rst_n) begin
      e = 0; m_active = 0; m_valid = 0; m_hold = 0;
      m_rdc = 0; m_wrc = 0; m_er = 0; m_ec = 0;
      m_dq = 16'd0; m_dqk = 2'b11; m_tgt = 8'd0;
    end else begin
      e++;
      wen_m = !ce_b && !we_b;
      ren_m = !ce_b && !oe_b && we_b;
      if (wen_m) begin
        if (m_wrc < 65535) m_wrc++;
        if (!oe_b) m_ec = 1;
        if (addr < DEPTH) begin
          for (int i = 0; i < 2; i++) begin
            if (!be_b[i]) begin
              m_mem[addr][8*i +: 8] = drv[8*i +: 8];
              m_known[addr][i] = 1'b1;
            end
          end
        end else begin
          m_er = 1;
        end
      end
      if (!ren_m) begin
        m_active = 0; m_valid = 0; m_hold = 0;
      end else if (!m_active) begin
        m_active = 1; m_valid = 0; m_hold = 0;
        m_tgt = addr; cap_e = e + ACC;
      end else if (m_valid) begin
        if (addr != m_tgt) begin
          m_tgt = addr; m_valid = 0;
          if (HOLD > 0) begin
            m_hold = 1; hold_e = e + HOLD; cap_e = hold_e + ACC;
          end else begin
            cap_e = e + ACC;
          end
        end
      end else if (m_hold) begin
        m_tgt = addr;
        if (e == hold_e) m_hold = 0;
      end else if (addr != m_tgt) begin
        m_tgt = addr; cap_e = e + ACC;
      end else if (e == cap_e) begin
        m_valid = 1;
        if (m_rdc < 65535) m_rdc++;
        if (m_tgt < DEPTH) begin
          m_dq = m_mem[m_tgt]; m_dqk = m_known[m_tgt];
        end else begin
          m_dqk = 2'b00; m_er = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit         ren_c;
    logic [7:0] lane;
    if (rst_n) begin
      ren_c = !ce_b && !oe_b && we_b;
      chk("rd_valid", 32'(rd_valid), 32'(m_valid && ren_c));
      chk("rd_count", 32'(rd_count), 32'(m_rdc));
      chk("wr_count", 32'(wr_count), 32'(m_wrc));
      chk("err_range", 32'(err_range), 32'(m_er));
      chk("err_contention", 32'(err_contention), 32'(m_ec));
      for (int i = 0; i < 2; i++) begin
        lane = data[8*i +: 8];
        if (!we_b) chk("bus_during_write", 32'(lane), 32'(drv[8*i +: 8]));
        else if (ren_c && !be_b[i] && m_active) begin
          if ((m_valid || m_hold) && m_dqk[i]) chk("bus_read_lane", 32'(lane), 32'(m_dq[8*i +: 8]));
        end else chk_z("bus_released", lane);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
    ce_b = 0; we_b = 0; oe_b = 1; addr = a; drv = d; be_b = b;
    tick();
  endtask

  task automatic rd_start(input logic [7:0] a, input logic [1:0] b);
    ce_b = 0; we_b = 1; oe_b = 0; addr = a; be_b = b;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, len;
    // Reset state
    repeat (3) tick();
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_count", 32'(rd_count), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_err_range", 32'(err_range), 32'd0);
    chk("rst_err_cont", 32'(err_contention), 32'd0);
    chk_z("rst_bus_lo", data[7:0]);
    chk_z("rst_bus_hi", data[15:8]);
    rst_n = 1;

    // Basic write then read with latency
    wr(8'd3, 16'hA55A, 2'b00);
    rd_start(8'd3, 2'b00);
    for (int k = 0; k < 4; k++) begin
      chk("latency_low", 32'(rd_valid), 32'd0);
      tick();
    end
    chk("latency_high", 32'(rd_valid), 32'd1);
    chk("read_a55a", 32'(data), 32'h0000A55A);
    chk("rd_count_1", 32'(rd_count), 32'd1);
    chk("wr_count_1", 32'(wr_count), 32'd1);

    // Byte lanes
    wr(8'd5, 16'h1234, 2'b00);
    wr(8'd5, 16'hFF00, 2'b10);
    wr(8'd7, 16'hBEEF, 2'b00);
    rd_start(8'd5, 2'b00);
    repeat (4) tick();
    chk("lane_merge_valid", 32'(rd_valid), 32'd1);
    chk("lane_merge", 32'(data), 32'h00001200);
    be_b = 2'b01;
    #1;
    chk("be_upper", 32'(data[15:8]), 32'h12);
    chk_z("be_lower", data[7:0]);
    be_b = 2'b00;

    // Address change while valid: hold old data, then X, then new data
    addr = 8'd7;
    tick();
    chk("hold0_valid", 32'(rd_valid), 32'd0);
    chk("hold0_data", 32'(data), 32'h00001200);
    tick();
    chk("hold1_valid", 32'(rd_valid), 32'd0);
    chk("hold1_data", 32'(data), 32'h00001200);
    repeat (4) begin
      tick();
      chk("reaccess_valid", 32'(rd_valid), 32'd0);
    end
    tick();
    chk("new_valid", 32'(rd_valid), 32'd1);
    chk("new_data", 32'(data), 32'h0000BEEF);

    // Contention: write still happens, flag sticks
    ce_b = 0; we_b = 0; oe_b = 0; addr = 8'd9; drv = 16'h5A5A; be_b = 2'b00;
    tick();
    chk("contention_flag", 32'(err_contention), 32'd1);
    chk("contention_bus", 32'(data), 32'h00005A5A);
    rd_start(8'd9, 2'b00);
    repeat (4) tick();
    chk("contention_readback", 32'(data), 32'h00005A5A);
    ce_b = 1; oe_b = 1;
    repeat (3) tick();
    chk("contention_sticky", 32'(err_contention), 32'd1);
    rst_n = 0;
    #1;
    chk("contention_cleared", 32'(err_contention), 32'd0);
    tick();
    rst_n = 1;

    // Out-of-range read and write
    rd_start(8'(DEPTH), 2'b00);
    repeat (3) tick();
    chk("range_before_cap", 32'(err_range), 32'd0);
    tick();
    chk("range_rd_valid", 32'(rd_valid), 32'd1);
    chk("range_rd_flag", 32'(err_range), 32'd1);
    rst_n = 0;
    tick();
    rst_n = 1;
    wr(8'(DEPTH), 16'h1111, 2'b00);
    chk("range_wr_flag", 32'(err_range), 32'd1);
    chk("range_wr_count", 32'(wr_count), 32'd1);

    // Reset during access
    rd_start(8'd3, 2'b00);
    tick();
    #2;
    rst_n = 0;
    #1;
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("midrst_wr_count", 32'(wr_count), 32'd0);
    chk("midrst_rd_count", 32'(rd_count), 32'd0);
    chk("midrst_err_range", 32'(err_range), 32'd0);
    chk_z("midrst_bus_lo", data[7:0]);
    chk_z("midrst_bus_hi", data[15:8]);
    tick();
    rst_n = 1;

    // Randomized traffic
    for (int a = 0; a < 16; a++) wr(8'(a), 16'($urandom), 2'b00);
    for (int s = 0; s < 400; s++) begin
      op = $urandom_range(0, 9);
      if (op <= 1) begin
        len = $urandom_range(1, 3);
        for (int c = 0; c < len; c++) begin
          ce_b = 0; we_b = 0;
          oe_b = ($urandom_range(0, 7) != 0);
          addr = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(195, 255)) : 8'($urandom_range(0, 15));
          drv = 16'($urandom);
          be_b = 2'($urandom);
          tick();
        end
      end else if (op <= 7) begin
        len = $urandom_range(1, 14);
        ce_b = 0; we_b = 1; oe_b = 0;
        addr = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(195, 210)) : 8'($urandom_range(0, 15));
        be_b = 2'($urandom);
        for (int c = 0; c < len; c++) begin
          if ($urandom_range(0, 3) == 0) be_b = 2'($urandom);
          if ($urandom_range(0, 6) == 0) addr = 8'($urandom_range(0, 15));
          tick();
        end
      end else begin
        len = $urandom_range(1, 3);
        for (int c = 0; c < len; c++) begin
          ce_b = (op == 8) ? 1'b1 : 1'($urandom);
          we_b = 1'b1;
          oe_b = (op == 8) ? 1'($urandom) : 1'b1;
          addr = 8'($urandom_range(0, 15));
          tick();
        end
      end
    end

    // Write counter saturation
    rst_n = 0;
    tick();
    rst_n = 1;
    ce_b = 0; we_b = 0; oe_b = 1; addr = 8'd1; be_b = 2'b00;
    for (int c = 0; c < 70000; c++) begin
      drv = 16'(c);
      tick();
    end
    chk("wr_count_saturated", 32'(wr_count), 32'h0000FFFF);
    ce_b = 1; we_b = 1;
    tick();
    chk("wr_count_held", 32'(wr_count), 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/async_sram_model.md
# async_sram_model

Parametrised, clocked behavioural model of an asynchronous SRAM used in testbenches as external memory for the FPGA design. It generalises our fixed 512K×8 part model to any data width (in whole bytes) and depth, and adds per-byte lane enables. It also emulates access latency and data hold with a read state machine, and reports misuse through sticky error flags and activity counters. It sits on the board-level bus in the testbench, driven by the DUT's SRAM controller pins.

## Interface
Parameters:
- DATA_W, 8: data bus width; must be a multiple of 8; NB = DATA_W/8 byte lanes
- ADDR_W, 19: address width
- DEPTH, 524288: number of words; DEPTH ≤ 2^ADDR_W
- ACCESS_CYC, 4: read access latency in clk cycles; ≥ 1
- HOLD_CYC, 1: cycles old data stays driven after an address change; ≥ 0

Ports:
- clk  input  1  model clock; all state on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- data  inout  DATA_W  bidirectional SRAM data bus
- ce_b  input  1  chip enable, active-low
- we_b  input  1  write enable, active-low
- oe_b  input  1  output enable, active-low
- be_b  input  NB  byte-lane enables, active-low; bit i covers data[8i+7:8i]
- addr  input  ADDR_W  word address
- rd_valid  output  1  driven read data is valid for addr_q
- rd_count  output  16  completed reads, saturating
- wr_count  output  16  write edges, saturating
- err_range  output  1  sticky: access with addr ≥ DEPTH
- err_contention  output  1  sticky: ce_b, we_b, oe_b all low at an edge

## Operation
- Memory: DEPTH × DATA_W array; never reset; initial contents X.
- wen = !ce_b & !we_b; ren = !ce_b & !oe_b & we_b. Write has priority; the model never drives the bus while we_b is low.
- Write:
  - At each edge with wen and addr < DEPTH, lanes with be_b[i]=0 take data lanes; other lanes are unchanged.
  - wr_count increments, saturating at 16'hFFFF.
  - addr ≥ DEPTH: no write, err_range set.
- Contention: wen & !oe_b at an edge sets err_contention; the write still happens.
- Read FSM states IDLE, ACCESS, HOLD, VALID; registers addr_q, cnt, dq.
  - Any state, ren=0 at edge → IDLE, rd_valid=0.
  - IDLE, ren=1 → ACCESS, addr_q←addr, cnt←1.
  - ACCESS:
    - addr≠addr_q → addr_q←addr, cnt←1 (restart).
    - Otherwise, if cnt==ACCESS_CYC → dq←mem[addr_q], rd_count++ (saturating), go VALID.
    - Otherwise cnt++.
  - VALID:
    - addr≠addr_q, HOLD_CYC>0 → HOLD, addr_q←addr, cnt←1.
    - addr≠addr_q, HOLD_CYC=0 → ACCESS, addr_q←addr, cnt←1.
  - HOLD:
    - addr change → addr_q←addr, hold count continues.
    - When cnt==HOLD_CYC → ACCESS, cnt←1; otherwise cnt++.
- Read of addr ≥ DEPTH: dq←all-X, err_range set, VALID still reached.
- Bus drive is combinational from pins and state:
  - Lane i is driven only when ren=1, be_b[i]=0 and state≠IDLE; otherwise Z.
  - Driven value: dq in VALID and HOLD; all-X in ACCESS.
- rd_valid=1 only in VALID while ren=1.

## Timing
- Reset values (immediately on rst_n low): state IDLE, rd_valid 0, rd_count 0, wr_count 0, err_range 0, err_contention 0, dq 0, addr_q 0, cnt 0; bus Z.
- Reset mid-read: bus releases to Z asynchronously; an active access is abandoned.
- Read latency: ren and addr A sampled at edge n → VALID and rd_valid=1 after edge n+ACCESS_CYC; data = mem[A] as of edge n+ACCESS_CYC.
- Address change sampled at edge m while VALID → old dq driven until edge m+HOLD_CYC, then X, then new data valid after edge m+HOLD_CYC+ACCESS_CYC.
- oe_b/ce_b deassert: bus Z combinationally, same cycle; FSM reaches IDLE at the next edge.
- Write visible to a read whose capture edge is later than the write edge.
- Counters stop at 16'hFFFF; flags clear only on reset.

## Test plan
- Reset, DATA_W=16, write 16'hA55A to addr 3 with be_b=2'b00, then read addr 3 → rd_valid high exactly ACCESS_CYC=4 edges after sampling, data=16'hA55A, rd_count=1, wr_count=1.
- Byte lanes: write 16'h1234, then write 16'hFF00 with be_b=2'b10 → readback 16'h1200; read with be_b=2'b01 → upper lane 8'h12, lower lane Z.
- Address change in VALID with HOLD_CYC=2: old data held for 2 edges, X for 4, then new data; rd_valid low throughout the transition.
- ce_b=we_b=oe_b=0 at one edge → write performed, bus never driven, err_contention=1 and remaining 1 until rst_n pulse.
- Access at addr=DEPTH → no write, read returns X, err_range=1.
- Assert rst_n low in ACCESS → bus Z and all outputs zero immediately; 70000 writes → wr_count=16'hFFFF.
